// File: rtl/branch_stat_ctr.sv
// branch_stat_ctr: branch/BTB-hit/mispredict statistics counters with a
// snapshot mode and an atomic LO/HI read path through a shared shadow.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   inc_br_cnt          branch reached EX this cycle
//   inc_hit_cnt         BTB hit this cycle
//   inc_mispr_cnt       BTB misprediction this cycle
//   addr[2:0]           0 BR_LO 1 BR_HI 2 HIT_LO 3 HIT_HI
//                       4 MIS_LO 5 MIS_HI 6 CTRL 7 STATUS
//   re, we, wdata[15:0] register read/write strobes and write data
//   rdata[15:0], rd_vld read data, valid one cycle after re

module branch_stat_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  input  logic [2:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SNAP = 2'b10
  } state_t;

  localparam logic [2:0]  A_CTRL  = 3'd6;
  localparam logic [2:0]  A_STAT  = 3'd7;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t state;
  state_t state_nxt;

  logic [31:0] br_cnt;
  logic [31:0] hit_cnt;
  logic [31:0] mis_cnt;
  logic [31:0] br_snap;
  logic [31:0] hit_snap;
  logic [31:0] mis_snap;
  logic [15:0] shadow;
  logic [2:0]  ovf;
  logic [2:0]  ovf_nxt;

  logic        ctrl_wr;
  logic        w_en;
  logic        w_clr;
  logic        w_snap;
  logic        clr;
  logic        cnt_en;
  logic        snap_take;
  logic        br_sat;
  logic        hit_sat;
  logic        mis_sat;
  logic        br_inc;
  logic        hit_inc;
  logic        mis_inc;

  logic        is_ctrl;
  logic        is_stat;
  logic        is_hi;
  logic        is_lo;
  logic [31:0] src;
  logic [15:0] rd_nxt;

  logic        unused_wdata;

  assign unused_wdata = ^wdata[15:3];

  assign ctrl_wr = we && (addr == A_CTRL);
  assign w_en    = wdata[0];
  assign w_clr   = wdata[1];
  assign w_snap  = wdata[2];
  assign clr     = ctrl_wr && w_clr;

  // Live counters run in RUN and keep running underneath SNAP.
  assign cnt_en  = (state == RUN) || (state == SNAP);

  assign br_sat  = (br_cnt  == CNT_MAX);
  assign hit_sat = (hit_cnt == CNT_MAX);
  assign mis_sat = (mis_cnt == CNT_MAX);

  assign br_inc  = cnt_en && inc_br_cnt;
  assign hit_inc = cnt_en && inc_hit_cnt;
  assign mis_inc = cnt_en && inc_mispr_cnt;

  assign snap_take = (state != SNAP) && (state_nxt == SNAP);

  always_comb begin
    state_nxt = state;
    if (ctrl_wr) begin
      unique case (state)
        IDLE: begin
          if (w_en) state_nxt = w_snap ? SNAP : RUN;
        end
        RUN: begin
          if (!w_en)       state_nxt = IDLE;
          else if (w_snap) state_nxt = SNAP;
        end
        SNAP: begin
          if (!w_snap) state_nxt = w_en ? RUN : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sticky overflow: an increment blocked by saturation sets the bit.
  always_comb begin
    ovf_nxt = ovf;
    if (br_inc  && br_sat)  ovf_nxt[0] = 1'b1;
    if (hit_inc && hit_sat) ovf_nxt[1] = 1'b1;
    if (mis_inc && mis_sat) ovf_nxt[2] = 1'b1;
    if (clr)                ovf_nxt    = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= '0;
    else        ovf <= ovf_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      hit_cnt <= '0;
      mis_cnt <= '0;
    end else if (clr) begin
      br_cnt  <= '0;
      hit_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      if (br_inc  && !br_sat)  br_cnt  <= br_cnt  + 32'd1;
      if (hit_inc && !hit_sat) hit_cnt <= hit_cnt + 32'd1;
      if (mis_inc && !mis_sat) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  // Snapshot captures the pre-edge live values on SNAP entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_snap  <= '0;
      hit_snap <= '0;
      mis_snap <= '0;
    end else if (clr) begin
      br_snap  <= '0;
      hit_snap <= '0;
      mis_snap <= '0;
    end else if (snap_take) begin
      br_snap  <= br_cnt;
      hit_snap <= hit_cnt;
      mis_snap <= mis_cnt;
    end
  end

  assign is_ctrl = (addr == A_CTRL);
  assign is_stat = (addr == A_STAT);
  assign is_hi   = addr[0] && !is_stat;
  assign is_lo   = !addr[0] && !is_ctrl;

  always_comb begin
    src = '0;
    unique case (addr[2:1])
      2'd0:    src = (state == SNAP) ? br_snap  : br_cnt;
      2'd1:    src = (state == SNAP) ? hit_snap : hit_cnt;
      2'd2:    src = (state == SNAP) ? mis_snap : mis_cnt;
      default: src = '0;
    endcase
  end

  // CTRL/STATUS reflect this edge's write; counters are pre-edge.
  always_comb begin
    rd_nxt = '0;
    unique case (1'b1)
      is_ctrl: rd_nxt = {13'b0, state_nxt == SNAP,
                         1'b0, state_nxt != IDLE};
      is_stat: rd_nxt = {10'b0, state_nxt, 1'b0, ovf_nxt};
      is_hi:   rd_nxt = shadow;
      is_lo:   rd_nxt = src[15:0];
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            shadow <= '0;
    else if (clr)          shadow <= '0;
    else if (re && is_lo)  shadow <= src[31:16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_vld <= re;
      if (re) rdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_branch_stat_ctr.sv
// tb_branch_stat_ctr: vector table plus directed sequences for
// branch_stat_ctr, with a read-data scoreboard.

module tb_branch_stat_ctr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_br_cnt = 1'b0;
  logic        inc_hit_cnt = 1'b0;
  logic        inc_mispr_cnt = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        rd_vld;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_stat_ctr dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc_br_cnt    (inc_br_cnt),
    .inc_hit_cnt   (inc_hit_cnt),
    .inc_mispr_cnt (inc_mispr_cnt),
    .addr          (addr),
    .re            (re),
    .we            (we),
    .wdata         (wdata),
    .rdata         (rdata),
    .rd_vld        (rd_vld)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic [2:0]  inc;
    logic        w;
    logic        r;
    logic [2:0]  a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  logic        re_q;
  logic [15:0] last_rd = 16'h0;

  // Expected rd_vld: one cycle after a sampled re, killed by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) re_q <= 1'b0;
    else        re_q <= re;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) last_rd = 16'h0;
    checks++;
    if (rd_vld !== re_q) begin
      failures++;
      $display("FAIL rd_vld t=%0t got=%b exp=%b", $time, rd_vld, re_q);
    end
    if (rd_vld === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected t=%0t got=%h", $time, rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.d) begin
          failures++;
          $display("FAIL rd addr=%0d t=%0t got=%h exp=%h",
                   e.a, $time, rdata, e.d);
        end
      end
      last_rd = rdata;
    end else begin
      checks++;
      if (rdata !== last_rd) begin
        failures++;
        $display("FAIL rdata_hold t=%0t got=%h exp=%h",
                 $time, rdata, last_rd);
      end
    end
  end

  function automatic vec_t v(input logic [2:0] inc, input logic w,
                             input logic r, input logic [2:0] a,
                             input logic [15:0] wd,
                             input logic [15:0] exp);
    vec_t t;
    t.inc = inc; t.w = w; t.r = r; t.a = a; t.wd = wd; t.exp = exp;
    return t;
  endfunction

  task automatic cyc(input logic [2:0] inc, input logic w,
                     input logic r, input logic [2:0] a,
                     input logic [15:0] wd, input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = inc;
    we = w; re = r; addr = a; wdata = wd;
    if (r) begin
      e.a = a; e.d = exp;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp);
    cyc(3'b000, 1'b0, 1'b1, a, 16'h0, exp);
  endtask

  task automatic wr(input logic [15:0] wd);
    cyc(3'b000, 1'b1, 1'b0, 3'd6, wd, 16'h0);
  endtask

  task automatic idle();
    cyc(3'b000, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  task automatic incs(input logic [2:0] inc, input int n);
    for (int i = 0; i < n; i++)
      cyc(inc, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, CTRL/STATUS, shadow after reset
    tbl.push_back(v(3'b000, 0, 1, 3'd7, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd6, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd1, 16'h0, 16'h0000));
    // RUN, 5 branches
    tbl.push_back(v(3'b000, 1, 0, 3'd6, 16'h0001, 16'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(3'b001, 0, 0, 3'd0, 16'h0, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0005));
    tbl.push_back(v(3'b000, 0, 1, 3'd7, 16'h0, 16'h0010));
    tbl.push_back(v(3'b000, 0, 1, 3'd6, 16'h0, 16'h0001));
    // HIT=7, enter SNAP, live keeps counting
    for (int i = 0; i < 7; i++)
      tbl.push_back(v(3'b010, 0, 0, 3'd0, 16'h0, 16'h0));
    tbl.push_back(v(3'b000, 1, 0, 3'd6, 16'h0005, 16'h0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(3'b010, 0, 0, 3'd0, 16'h0, 16'h0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v(3'b001, 0, 0, 3'd0, 16'h0, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd2, 16'h0, 16'h0007));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0005));
    tbl.push_back(v(3'b000, 0, 1, 3'd7, 16'h0, 16'h0020));
    tbl.push_back(v(3'b000, 0, 1, 3'd6, 16'h0, 16'h0005));
    // back to RUN: live values
    tbl.push_back(v(3'b000, 1, 0, 3'd6, 16'h0001, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd2, 16'h0, 16'h000A));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0007));
    // re+we on CTRL: post-write value, now IDLE
    tbl.push_back(v(3'b000, 1, 1, 3'd6, 16'h0000, 16'h0000));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v(3'b001, 0, 0, 3'd0, 16'h0, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0007));
    // ignored write to HIT_HI
    tbl.push_back(v(3'b000, 1, 0, 3'd3, 16'h0007, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd7, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0007));
    // IDLE->SNAP with read of CTRL in the same cycle
    tbl.push_back(v(3'b000, 1, 1, 3'd6, 16'h0005, 16'h0005));
    tbl.push_back(v(3'b001, 1, 1, 3'd0, 16'h1234, 16'h0007));
    tbl.push_back(v(3'b000, 1, 1, 3'd7, 16'h0001, 16'h0020));
    tbl.push_back(v(3'b000, 1, 0, 3'd6, 16'h0001, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0008));
    // all three counting, then CLR against incs
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(3'b111, 0, 0, 3'd0, 16'h0, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd4, 16'h0, 16'h0003));
    tbl.push_back(v(3'b000, 0, 1, 3'd2, 16'h0, 16'h000D));
    tbl.push_back(v(3'b111, 1, 0, 3'd6, 16'h0003, 16'h0));
    tbl.push_back(v(3'b000, 0, 1, 3'd0, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd2, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd4, 16'h0, 16'h0000));
    tbl.push_back(v(3'b000, 0, 1, 3'd7, 16'h0, 16'h0010));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].inc, tbl[i].w, tbl[i].r, tbl[i].a,
          tbl[i].wd, tbl[i].exp);
    idle();

    // atomic LO/HI pair across a carry
    @(negedge clk);
    force dut.br_cnt = 32'h0001_FFFF;
    #1;
    release dut.br_cnt;
    rd(3'd0, 16'hFFFF);
    incs(3'b001, 1);
    rd(3'd1, 16'h0001);
    rd(3'd0, 16'h0000);
    rd(3'd1, 16'h0002);
    idle();

    // saturation and sticky overflow, then CLR
    @(negedge clk);
    force dut.mis_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mis_cnt;
    incs(3'b100, 2);
    rd(3'd4, 16'hFFFF);
    rd(3'd5, 16'hFFFF);
    rd(3'd7, 16'h0014);
    wr(16'h0003);
    rd(3'd5, 16'h0000);
    rd(3'd4, 16'h0000);
    rd(3'd7, 16'h0010);

    // reset mid-count in SNAP with a read pending
    wr(16'h0005);
    incs(3'b111, 3);
    @(negedge clk);
    re = 1'b1; addr = 3'd0; we = 1'b0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    re = 1'b0;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, 16'h0000);
    rd(3'd2, 16'h0000);
    rd(3'd4, 16'h0000);
    rd(3'd1, 16'h0000);
    rd(3'd7, 16'h0000);
    rd(3'd6, 16'h0000);
    incs(3'b111, 2);
    rd(3'd0, 16'h0000);
    rd(3'd7, 16'h0000);
    idle();
    idle();
    idle();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
